// File: rtl/ee271_final_proj_v2.sv
// Vending-machine controller: edge-detected coin and selection inputs, price/quantity
// latching, payment check, and delivery/refund reporting with change.
module ee271_final_proj_v2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       cancel,
    input  logic       cont,
    input  logic [2:0] item_sel,
    input  logic [1:0] amt_sel,
    input  logic       DIME,
    input  logic       QUATER,
    input  logic       DOLLAR,
    output logic [2:0] state,
    output logic [2:0] next_state,
    output logic [9:0] collected,
    output logic [9:0] change,
    output logic [2:0] item,
    output logic [1:0] amt,
    output logic [2:0] delivery
);

    localparam int unsigned CW           = 10;
    localparam int unsigned DIME_CENTS   = 10;
    localparam int unsigned QUATER_CENTS = 25;
    localparam int unsigned DOLLAR_CENTS = 100;
    localparam int unsigned PRICE_STEP   = 25;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_AMT     = 3'd1,
        S_PAY     = 3'd2,
        S_DELIVER = 3'd3,
        S_REFUND  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t cur, nxt;

    logic       cancel_q, cont_q, dime_q, quater_q, dollar_q;
    logic [2:0] item_sel_q;
    logic [1:0] amt_sel_q;

    // Previous-cycle copies of every control input for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            cancel_q   <= 1'b0;
            cont_q     <= 1'b0;
            dime_q     <= 1'b0;
            quater_q   <= 1'b0;
            dollar_q   <= 1'b0;
            item_sel_q <= 3'd0;
            amt_sel_q  <= 2'd0;
        end else begin
            cancel_q   <= cancel;
            cont_q     <= cont;
            dime_q     <= DIME;
            quater_q   <= QUATER;
            dollar_q   <= DOLLAR;
            item_sel_q <= item_sel;
            amt_sel_q  <= amt_sel;
        end
    end

    logic cancel_ev, cont_ev, dime_ev, quater_ev, dollar_ev, item_ev, amt_ev;

    assign cancel_ev = cancel & ~cancel_q;
    assign cont_ev   = cont & ~cont_q;
    assign dime_ev   = DIME & ~dime_q;
    assign quater_ev = QUATER & ~quater_q;
    assign dollar_ev = DOLLAR & ~dollar_q;
    assign item_ev   = (item_sel != 3'd0) && (item_sel_q == 3'd0);
    assign amt_ev    = (amt_sel != 2'd0) && (amt_sel_q == 2'd0);

    logic [CW-1:0] coin_sum;
    logic [CW:0]   coin_total;
    logic          coin_state, coin_ok;
    logic [CW-1:0] cost;

    assign coin_sum   = (dime_ev   ? CW'(DIME_CENTS)   : '0)
                      + (quater_ev ? CW'(QUATER_CENTS) : '0)
                      + (dollar_ev ? CW'(DOLLAR_CENTS) : '0);
    assign coin_total = (CW+1)'(collected) + (CW+1)'(coin_sum);
    assign coin_state = (cur == S_IDLE) || (cur == S_AMT) || (cur == S_PAY);
    // A sum that would overflow the 10-bit total is rejected as a whole
    assign coin_ok    = coin_state && !coin_total[CW];
    assign cost       = CW'(item) * CW'(PRICE_STEP) * CW'(amt);

    logic latch_item, latch_amt;

    always_ff @(posedge clk) begin
        if (reset) cur <= S_IDLE;
        else       cur <= nxt;
    end

    // Next state and selection strobes; cancel outranks selection outranks payment
    always_comb begin
        nxt        = cur;
        latch_item = 1'b0;
        latch_amt  = 1'b0;
        case (cur)
            S_IDLE: begin
                if (cancel_ev && (collected != '0)) begin
                    nxt = S_REFUND;
                end else if (item_ev) begin
                    nxt        = S_AMT;
                    latch_item = 1'b1;
                end
            end
            S_AMT: begin
                if (cancel_ev) begin
                    nxt = S_REFUND;
                end else begin
                    latch_item = item_ev;
                    if (amt_ev) begin
                        nxt       = S_PAY;
                        latch_amt = 1'b1;
                    end
                end
            end
            S_PAY: begin
                if (cancel_ev)              nxt = S_REFUND;
                else if (collected >= cost) nxt = S_DELIVER;
            end
            S_DELIVER: nxt = S_DONE;
            S_REFUND:  nxt = S_DONE;
            S_DONE: begin
                if (cont_ev) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
        if (reset) nxt = S_IDLE;
    end

    // Money, selections and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            collected <= '0;
            change    <= '0;
            item      <= 3'd0;
            amt       <= 2'd0;
            delivery  <= 3'd0;
        end else begin
            case (cur)
                S_DELIVER: begin
                    delivery  <= 3'(amt);
                    change    <= collected - cost;
                    collected <= '0;
                end
                S_REFUND: begin
                    change    <= collected;
                    delivery  <= 3'd0;
                    collected <= '0;
                end
                S_DONE: begin
                    if (cont_ev) begin
                        change   <= '0;
                        delivery <= 3'd0;
                        item     <= 3'd0;
                        amt      <= 2'd0;
                    end
                end
                default: begin
                    if (coin_ok) collected <= coin_total[CW-1:0];
                end
            endcase
            if (latch_item) item <= item_sel;
            if (latch_amt)  amt  <= amt_sel;
        end
    end

    assign state      = cur;
    assign next_state = nxt;

endmodule

// File: tb/tb_ee271_final_proj_v2.sv
// Scoreboard bench for the vending controller: stimulus queues expected collected
// totals and transaction results; a monitor compares them as the DUT presents them.
module tb_ee271_final_proj_v2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_AMT     = 3'd1;
    localparam logic [2:0] ST_PAY     = 3'd2;
    localparam logic [2:0] ST_DELIVER = 3'd3;
    localparam logic [2:0] ST_REFUND  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    logic       clk = 1'b0;
    logic       reset, cancel, cont, dime, quater, dollar;
    logic [2:0] item_sel;
    logic [1:0] amt_sel;
    logic [2:0] state, next_state, item, delivery;
    logic [9:0] collected, change;
    logic [1:0] amt;

    ee271_final_proj_v2 dut (
        .clk       (clk),
        .reset     (reset),
        .cancel    (cancel),
        .cont      (cont),
        .item_sel  (item_sel),
        .amt_sel   (amt_sel),
        .DIME      (dime),
        .QUATER    (quater),
        .DOLLAR    (dollar),
        .state     (state),
        .next_state(next_state),
        .collected (collected),
        .change    (change),
        .item      (item),
        .amt       (amt),
        .delivery  (delivery)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] change;
        logic [2:0] delivery;
        logic [2:0] via;
    } result_t;

    int         total = 0;
    int         bad   = 0;
    int         coll_q[$];
    result_t    done_q[$];
    logic [2:0] last_state = 3'd0;
    logic [9:0] last_coll  = 10'd0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every nonzero change of collected and every entry into DONE is scored
    always @(negedge clk) begin
        if (!reset && collected != last_coll && collected != 10'd0) begin
            if (coll_q.size() == 0) begin
                check("collected_unexpected", int'(collected), int'(last_coll));
            end else begin
                check("collected", int'(collected), coll_q.pop_front());
            end
        end
        if (!reset && state == ST_DONE && last_state != ST_DONE) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", int'(state), int'(last_state));
            end else begin
                result_t r;
                r = done_q.pop_front();
                check("change",         int'(change),     int'(r.change));
                check("delivery",       int'(delivery),   int'(r.delivery));
                check("path",           int'(last_state), int'(r.via));
                check("collected_done", int'(collected),  0);
            end
        end
        if (!reset && state == ST_IDLE && last_state == ST_DONE) begin
            check("idle_change",   int'(change),   0);
            check("idle_delivery", int'(delivery), 0);
            check("idle_item",     int'(item),     0);
            check("idle_amt",      int'(amt),      0);
        end
        last_state = state;
        last_coll  = collected;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic coin(input logic d, input logic q, input logic l, input int hold);
        dime = d; quater = q; dollar = l;
        cyc(hold);
        dime = 1'b0; quater = 1'b0; dollar = 1'b0;
        cyc(1);
    endtask

    task automatic sel_item(input logic [2:0] v);
        item_sel = v; cyc(1); item_sel = 3'd0; cyc(1);
    endtask

    task automatic sel_amt(input logic [1:0] v);
        amt_sel = v; cyc(1); amt_sel = 2'd0; cyc(1);
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1; cyc(1); cancel = 1'b0; cyc(1);
    endtask

    task automatic pulse_cont();
        cont = 1'b1; cyc(1); cont = 1'b0; cyc(1);
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (state != s && n < 20) begin
            cyc(1);
            n++;
        end
        check(name, int'(state), int'(s));
    endtask

    task automatic close_txn();
        wait_state(ST_DONE, "reach_done");
        pulse_cont();
        wait_state(ST_IDLE, "back_idle");
    endtask

    function automatic result_t res(input int c, input int d, input logic [2:0] v);
        result_t r;
        r.change   = 10'(c);
        r.delivery = 3'(d);
        r.via      = v;
        return r;
    endfunction

    initial begin
        reset = 1'b1; cancel = 1'b0; cont = 1'b0;
        dime = 1'b0; quater = 1'b0; dollar = 1'b0;
        item_sel = 3'd0; amt_sel = 2'd0;
        cyc(3);
        check("rst_next_state", int'(next_state), 0);
        reset = 1'b0;
        cyc(1);
        check("rst_state",     int'(state),     0);
        check("rst_collected", int'(collected), 0);
        check("rst_change",    int'(change),    0);
        check("rst_delivery",  int'(delivery),  0);
        check("rst_item",      int'(item),      0);

        // Normal purchase: item 4 x2 = 200, three held dollars give 300
        sel_item(3'd4);
        check("item_latched", int'(item), 4);
        coll_q.push_back(100); coin(1'b0, 1'b0, 1'b1, 2);
        coll_q.push_back(200); coin(1'b0, 1'b0, 1'b1, 2);
        coll_q.push_back(300); coin(1'b0, 1'b0, 1'b1, 2);
        done_q.push_back(res(100, 2, ST_DELIVER));
        sel_amt(2'd2);
        close_txn();

        // Cancel before quantity is chosen
        sel_item(3'd5);
        coll_q.push_back(10); coin(1'b1, 1'b0, 1'b0, 1);
        coll_q.push_back(35); coin(1'b0, 1'b1, 1'b0, 1);
        done_q.push_back(res(35, 0, ST_REFUND));
        pulse_cancel();
        close_txn();

        // Cancel during PAY (cost 375)
        sel_item(3'd5);
        sel_amt(2'd3);
        check("in_pay", int'(state), int'(ST_PAY));
        coll_q.push_back(100); coin(1'b0, 1'b0, 1'b1, 1);
        done_q.push_back(res(100, 0, ST_REFUND));
        pulse_cancel();
        close_txn();

        // Idle cancel with nothing collected, then coins before selection (cost 125)
        pulse_cancel();
        check("idle_cancel_state", int'(state), int'(ST_IDLE));
        coll_q.push_back(10);  coin(1'b1, 1'b0, 1'b0, 1);
        sel_item(3'd5);
        coll_q.push_back(110); coin(1'b0, 1'b0, 1'b1, 1);
        sel_amt(2'd1);
        cyc(2);
        check("short_pay_state",    int'(state),    int'(ST_PAY));
        check("short_pay_delivery", int'(delivery), 0);
        coll_q.push_back(210);
        done_q.push_back(res(85, 1, ST_DELIVER));
        coin(1'b0, 1'b0, 1'b1, 1);
        close_txn();

        // Quarter and cancel in the same cycle during PAY (cost 525)
        sel_item(3'd7);
        sel_amt(2'd3);
        coll_q.push_back(100); coin(1'b0, 1'b0, 1'b1, 1);
        coll_q.push_back(125);
        done_q.push_back(res(125, 0, ST_REFUND));
        quater = 1'b1; cancel = 1'b1;
        cyc(1);
        quater = 1'b0; cancel = 1'b0;
        cyc(1);
        close_txn();

        // Dime+dollar together, continue outside DONE, then reset mid-PAY
        sel_item(3'd7);
        sel_amt(2'd3);
        coll_q.push_back(110); coin(1'b1, 1'b0, 1'b1, 1);
        pulse_cont();
        check("cont_ignored_state",     int'(state),     int'(ST_PAY));
        check("cont_ignored_collected", int'(collected), 110);
        coll_q.push_back(210); coin(1'b0, 1'b0, 1'b1, 1);
        reset = 1'b1;
        cyc(1);
        check("midrst_state",     int'(state),     0);
        check("midrst_collected", int'(collected), 0);
        check("midrst_change",    int'(change),    0);
        check("midrst_item",      int'(item),      0);
        check("midrst_amt",       int'(amt),       0);
        check("midrst_delivery",  int'(delivery),  0);
        reset = 1'b0;
        cyc(3);

        check("coll_q_drained", coll_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
